// File: rtl/stage_job_scheduler.sv
// stage_job_scheduler
//   Shares one A->B->C stage chain between NREQ requesters. A round-robin
//   arbiter picks an owner, then the block issues start_a/b/c pulses in turn,
//   waiting for done_a/b/c, and returns a one-cycle job_done pulse to the owner.
//   All outputs are registered.
//
//   Optional feature macro: SCHED_WATCHDOG_EN
//     When defined, a 16-bit per-stage wait counter aborts a job whose stage
//     stays silent for TMO_CYCLES cycles and pulses job_err to the owner.
//     When undefined, stage waits are unbounded and job_err is always 0.
//
//   Handshake: req is a level held by the requester until its job_done/job_err.
//   start_x is a single-cycle pulse; done_x is only looked at while the chain
//   waits on stage x (including the cycle start_x is high), and ignored otherwise.
module stage_job_scheduler #(
    parameter int NREQ       = 4,
    parameter int ID_W       = 2,
    parameter int TMO_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] cur_id,
    output logic            busy,
    output logic            start_a,
    output logic            start_b,
    output logic            start_c,
    input  logic            done_a,
    input  logic            done_b,
    input  logic            done_c,
    output logic [NREQ-1:0] job_done,
    output logic [NREQ-1:0] job_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_A = 2'd1,
        WAIT_B = 2'd2,
        WAIT_C = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] cur_id_q, cur_id_d;
    logic            busy_q, busy_d;
    logic            start_a_q, start_a_d;
    logic            start_b_q, start_b_d;
    logic            start_c_q, start_c_d;
    logic [NREQ-1:0] job_done_q, job_done_d;
    logic [NREQ-1:0] job_err_q, job_err_d;

    // Arbitration results
    logic            hi_found, lo_found;
    logic [ID_W-1:0] hi_idx, lo_idx;
    logic [NREQ-1:0] hi_oh, lo_oh;
    logic            pick_valid;
    logic [ID_W-1:0] pick_idx;
    logic [NREQ-1:0] pick_oh;

    logic            wd_expired;
    logic            job_finish;
    logic            job_abort;
    logic [ID_W-1:0] next_ptr;

    // Round-robin pick: lowest set request at or above the pointer, else lowest set overall
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        hi_oh    = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        lo_oh    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found  = 1'b1;
                lo_idx    = ID_W'(i);
                lo_oh     = '0;
                lo_oh[i]  = 1'b1;
                if (ID_W'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                    hi_oh    = '0;
                    hi_oh[i] = 1'b1;
                end
            end
        end
        pick_valid = hi_found | lo_found;
        pick_idx   = hi_found ? hi_idx : lo_idx;
        pick_oh    = hi_found ? hi_oh : lo_oh;
    end

    // Pointer after a job ends: owner + 1, wrapping at NREQ-1
    assign next_ptr = (cur_id_q == ID_W'(NREQ - 1)) ? '0 : cur_id_q + ID_W'(1);

`ifdef SCHED_WATCHDOG_EN
    localparam logic [15:0] WD_LIMIT = 16'(TMO_CYCLES - 1);

    logic [15:0] wd_cnt_q;

    // Per-stage wait counter: restarts on every state change, counts silent wait cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
        end else if (state_q == IDLE || state_d != state_q) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
        end
    end

    assign wd_expired = (state_q != IDLE) && (wd_cnt_q == WD_LIMIT);
`else
    assign wd_expired = 1'b0;
`endif

    // Next-state and next-output logic; a done_x beats a coincident timeout
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        cur_id_d   = cur_id_q;
        busy_d     = busy_q;
        start_a_d  = 1'b0;
        start_b_d  = 1'b0;
        start_c_d  = 1'b0;
        job_done_d = '0;
        job_err_d  = '0;
        job_finish = 1'b0;
        job_abort  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = WAIT_A;
                    gnt_d     = pick_oh;
                    cur_id_d  = pick_idx;
                    busy_d    = 1'b1;
                    start_a_d = 1'b1;
                end
            end
            WAIT_A: begin
                if (done_a) begin
                    state_d   = WAIT_B;
                    start_b_d = 1'b1;
                end else if (wd_expired) begin
                    job_abort = 1'b1;
                end
            end
            WAIT_B: begin
                if (done_b) begin
                    state_d   = WAIT_C;
                    start_c_d = 1'b1;
                end else if (wd_expired) begin
                    job_abort = 1'b1;
                end
            end
            WAIT_C: begin
                if (done_c) begin
                    job_finish = 1'b1;
                end else if (wd_expired) begin
                    job_abort = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (job_finish || job_abort) begin
            state_d  = IDLE;
            ptr_d    = next_ptr;
            gnt_d    = '0;
            cur_id_d = '0;
            busy_d   = 1'b0;
        end
        if (job_finish) begin
            job_done_d = gnt_q;
        end
`ifdef SCHED_WATCHDOG_EN
        if (job_abort) begin
            job_err_d = gnt_q;
        end
`endif
    end

    // State, pointer and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            cur_id_q   <= '0;
            busy_q     <= 1'b0;
            start_a_q  <= 1'b0;
            start_b_q  <= 1'b0;
            start_c_q  <= 1'b0;
            job_done_q <= '0;
            job_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            cur_id_q   <= cur_id_d;
            busy_q     <= busy_d;
            start_a_q  <= start_a_d;
            start_b_q  <= start_b_d;
            start_c_q  <= start_c_d;
            job_done_q <= job_done_d;
            job_err_q  <= job_err_d;
        end
    end

    assign gnt      = gnt_q;
    assign cur_id   = cur_id_q;
    assign busy     = busy_q;
    assign start_a  = start_a_q;
    assign start_b  = start_b_q;
    assign start_c  = start_c_q;
    assign job_done = job_done_q;
    assign job_err  = job_err_q;

endmodule

// File: tb/tb_stage_job_scheduler.sv
// Bench for stage_job_scheduler: directed scenarios plus a randomized job
// stream, checked against a transaction-level model (round-robin pick by
// modulo scan, expected-owner queue, fixed pulse latencies).
module tb_stage_job_scheduler;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] cur_id;
    logic            busy;
    logic            start_a, start_b, start_c;
    logic            done_a = 1'b0, done_b = 1'b0, done_c = 1'b0;
    logic [NREQ-1:0] job_done;
    logic [NREQ-1:0] job_err;

    stage_job_scheduler #(
        .NREQ       (NREQ),
        .ID_W       (ID_W),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .gnt      (gnt),
        .cur_id   (cur_id),
        .busy     (busy),
        .start_a  (start_a),
        .start_b  (start_b),
        .start_c  (start_c),
        .done_a   (done_a),
        .done_b   (done_b),
        .done_c   (done_c),
        .job_done (job_done),
        .job_err  (job_err)
    );

    // Clock
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: round-robin pointer and queue of granted owners
    int              ptr_m = 0;
    logic [ID_W-1:0] exp_q[$];

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] mask, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req     = '0;
        done_a  = 1'b0;
        done_b  = 1'b0;
        done_c  = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        ptr_m   = 0;
        exp_q.delete();
    endtask

    // Current req (driven in an idle cycle) is arbitrated at the next edge
    task automatic arbitrate(input string tag);
        int w;
        w = model_pick(req, ptr_m);
        exp_q.push_back(ID_W'(w));
        step();
        n_vec++;
        if (start_a !== 1'b1 || start_b !== 1'b0 || start_c !== 1'b0 ||
            gnt !== oh(w) || cur_id !== ID_W'(w) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s_grant: start_abc=%b%b%b gnt=%b cur_id=%0d busy=%b, want start_abc=100 gnt=%b cur_id=%0d busy=1",
                     tag, start_a, start_b, start_c, gnt, cur_id, busy, oh(w), w);
        end
    endtask

    // Starting in the start_a cycle, answer each stage after d cycles; ends in the job_done cycle
    task automatic run_stages(input string tag, input int da, input int db, input int dc,
                              input bit stray, output int owner);
        int              d[3];
        logic [ID_W-1:0] own;
        logic [2:0]      want;
        d[0] = da;
        d[1] = db;
        d[2] = dc;
        own  = exp_q[0];
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < d[s]; j++) begin
                if (stray && j == 0) begin
                    if (s == 0) done_b = 1'b1;
                    else if (s == 1) done_c = 1'b1;
                    else done_a = 1'b1;
                end
                step();
                done_a = 1'b0;
                done_b = 1'b0;
                done_c = 1'b0;
                n_vec++;
                if ({start_a, start_b, start_c} !== 3'b000 || busy !== 1'b1 ||
                    job_done !== '0 || gnt !== oh(own)) begin
                    n_err++;
                    $display("FAIL %s_wait_s%0d: start_abc=%b%b%b busy=%b job_done=%b gnt=%b, want 000 1 0000 %b",
                             tag, s, start_a, start_b, start_c, busy, job_done, gnt, oh(own));
                end
            end
            if (s == 0) done_a = 1'b1;
            else if (s == 1) done_b = 1'b1;
            else done_c = 1'b1;
            step();
            done_a = 1'b0;
            done_b = 1'b0;
            done_c = 1'b0;
            n_vec++;
            if (s < 2) begin
                want = (s == 0) ? 3'b010 : 3'b001;
                if ({start_a, start_b, start_c} !== want || busy !== 1'b1 || job_done !== '0) begin
                    n_err++;
                    $display("FAIL %s_next_s%0d: start_abc=%b%b%b busy=%b job_done=%b, want %b 1 0000",
                             tag, s, start_a, start_b, start_c, busy, job_done, want);
                end
            end else begin
                void'(exp_q.pop_front());
                if (job_done !== oh(own) || job_err !== '0 || gnt !== '0 || cur_id !== '0 ||
                    busy !== 1'b0 || {start_a, start_b, start_c} !== 3'b000) begin
                    n_err++;
                    $display("FAIL %s_job_done: job_done=%b job_err=%b gnt=%b cur_id=%0d busy=%b start_abc=%b%b%b, want %b 0000 0000 0 0 000",
                             tag, job_done, job_err, gnt, cur_id, busy, start_a, start_b, start_c, oh(own));
                end
                ptr_m = (int'(own) + 1) % NREQ;
            end
        end
        owner = int'(own);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int j = 0; j < cycles; j++) begin
            step();
            n_vec++;
            if (busy !== 1'b0 || start_a !== 1'b0 || job_done !== '0 || gnt !== '0) begin
                n_err++;
                $display("FAIL %s_idle: busy=%b start_a=%b job_done=%b gnt=%b, want 0 0 0000 0000",
                         tag, busy, start_a, job_done, gnt);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b1111;
        step();
        n_vec++;
        if (gnt !== '0 || cur_id !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_grant: gnt=%b cur_id=%0d busy=%b, want 0000 0 0", gnt, cur_id, busy);
        end
        n_vec++;
        if ({start_a, start_b, start_c} !== 3'b000 || job_done !== '0 || job_err !== '0) begin
            n_err++;
            $display("FAIL reset_pulses: start_abc=%b%b%b job_done=%b job_err=%b, want all 0",
                     start_a, start_b, start_c, job_done, job_err);
        end
        apply_reset();
    endtask

    task automatic test_single_job();
        int own;
        apply_reset();
        req = 4'b0010;
        arbitrate("single");
        n_vec++;
        if (cur_id !== 2'd1 || gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL single_owner: cur_id=%0d gnt=%b, want 1 0010", cur_id, gnt);
        end
        run_stages("single", 2, 2, 2, 1'b0, own);
        req = '0;
        idle_check("single", 3);
    endtask

    task automatic test_fairness();
        int order_a[4] = '{0, 1, 2, 3};
        int order_b[3] = '{0, 3, 0};
        int own;
        apply_reset();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            arbitrate("fair_a");
            n_vec++;
            if (cur_id !== ID_W'(order_a[k])) begin
                n_err++;
                $display("FAIL fair_a_order%0d: cur_id=%0d, want %0d", k, cur_id, order_a[k]);
            end
            run_stages("fair_a", $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, own);
        end
        req = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            arbitrate("fair_b");
            n_vec++;
            if (cur_id !== ID_W'(order_b[k])) begin
                n_err++;
                $display("FAIL fair_b_order%0d: cur_id=%0d, want %0d", k, cur_id, order_b[k]);
            end
            run_stages("fair_b", $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, own);
        end
        req = '0;
        idle_check("fair", 2);
    endtask

    task automatic test_stray_zero_latency();
        int own;
        req = 4'b0100;
        arbitrate("stray");
        run_stages("stray", 3, 2, 2, 1'b1, own);
        req = '0;
        idle_check("stray", 1);
        req = 4'b0001;
        arbitrate("zero_lat");
        run_stages("zero_lat", 0, 0, 0, 1'b0, own);
        req = '0;
        idle_check("zero_lat", 1);
    endtask

    task automatic test_reset_mid_job();
        int own;
        apply_reset();
        req = 4'b0001;
        arbitrate("rst_mid");
        done_a = 1'b1;
        step();
        done_a = 1'b0;
        n_vec++;
        if (start_b !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_start_b: start_b=%b, want 1", start_b);
        end
        step();
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (gnt !== '0 || cur_id !== '0 || busy !== 1'b0 || {start_a, start_b, start_c} !== 3'b000 ||
            job_done !== '0 || job_err !== '0) begin
            n_err++;
            $display("FAIL rst_mid_async: gnt=%b cur_id=%0d busy=%b start_abc=%b%b%b job_done=%b job_err=%b, want all 0",
                     gnt, cur_id, busy, start_a, start_b, start_c, job_done, job_err);
        end
        done_b = 1'b1;
        for (int j = 0; j < 2; j++) begin
            step();
            n_vec++;
            if (job_done !== '0 || job_err !== '0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_hold: job_done=%b job_err=%b busy=%b, want 0000 0000 0", job_done, job_err, busy);
            end
        end
        done_b  = 1'b0;
        reset_n = 1'b1;
        ptr_m   = 0;
        exp_q.delete();
        arbitrate("rst_after");
        n_vec++;
        if (cur_id !== 2'd0) begin
            n_err++;
            $display("FAIL rst_after_owner: cur_id=%0d, want 0", cur_id);
        end
        run_stages("rst_after", 1, 1, 1, 1'b0, own);
        req = '0;
        idle_check("rst_after", 1);
    endtask

    task automatic test_watchdog();
        int own;
        apply_reset();
        req = 4'b1000;
        arbitrate("wdog");
        done_a = 1'b1;
        step();
        done_a = 1'b0;
        done_b = 1'b1;
        step();
        done_b = 1'b0;
        n_vec++;
        if (start_c !== 1'b1) begin
            n_err++;
            $display("FAIL wdog_start_c: start_c=%b, want 1", start_c);
        end
`ifdef SCHED_WATCHDOG_EN
        for (int j = 1; j < TMO; j++) begin
            step();
            n_vec++;
            if (busy !== 1'b1 || job_err !== '0 || job_done !== '0) begin
                n_err++;
                $display("FAIL wdog_wait%0d: busy=%b job_err=%b job_done=%b, want 1 0000 0000", j, busy, job_err, job_done);
            end
        end
        step();
        n_vec++;
        if (job_err !== 4'b1000 || busy !== 1'b0 || gnt !== '0 || cur_id !== '0 || job_done !== '0) begin
            n_err++;
            $display("FAIL wdog_abort: job_err=%b busy=%b gnt=%b cur_id=%0d job_done=%b, want 1000 0 0000 0 0000",
                     job_err, busy, gnt, cur_id, job_done);
        end
        void'(exp_q.pop_front());
        ptr_m = 0;
        req   = 4'b1001;
        step();
        n_vec++;
        if (job_err !== '0 || start_a !== 1'b0 || {start_b, start_c} !== 2'b00) begin
            n_err++;
            $display("FAIL wdog_after: job_err=%b start_abc=%b%b%b, want 0000 000", job_err, start_a, start_b, start_c);
        end
        arbitrate("wdog_next");
        run_stages("wdog_next", 1, 0, 2, 1'b0, own);
        req = '0;
        idle_check("wdog_next", 1);
`else
        for (int j = 0; j < 100; j++) begin
            step();
            n_vec++;
            if (busy !== 1'b1 || job_err !== '0 || job_done !== '0) begin
                n_err++;
                $display("FAIL nowdog_wait%0d: busy=%b job_err=%b job_done=%b, want 1 0000 0000", j, busy, job_err, job_done);
            end
        end
        own = 0;
        apply_reset();
`endif
    endtask

    task automatic test_back_to_back();
        int own;
        apply_reset();
        req = 4'b0011;
        arbitrate("b2b_0");
        run_stages("b2b_0", 0, 0, 0, 1'b0, own);
        arbitrate("b2b_1");
        n_vec++;
        if (gnt !== 4'b0010 || start_a !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_next_grant: gnt=%b start_a=%b, want 0010 1", gnt, start_a);
        end
        run_stages("b2b_1", 0, 0, 0, 1'b0, own);
        req = 4'b0001;
        arbitrate("b2b_2");
        run_stages("b2b_2", 0, 0, 0, 1'b0, own);
        req = '0;
        idle_check("b2b", 1);
    endtask

    task automatic test_random();
        int own;
        for (int k = 0; k < 40; k++) begin
            if (req == '0) req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            arbitrate("rand");
            run_stages("rand", $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), own);
            if ($urandom_range(0, 1) == 1) req[own] = 1'b0;
            req = req | (NREQ'($urandom_range(0, 15)) & NREQ'($urandom_range(0, 15)));
            if (req == '0) idle_check("rand", $urandom_range(1, 2));
        end
        req = '0;
        idle_check("rand_end", 1);
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_fairness();
        test_stray_zero_latency();
        test_reset_mid_job();
        test_watchdog();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
